pwm_compare_deadtime: RTL and testbench
=======================================

PWM_COMPARE_DEADTIME -- requirements
Module: pwm_compare_deadtime

Interface
REQ-001 SHALL have parameter DT_WIDTH, default 8: width of the dead-time count.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port ce, input, 1: clock enable; when low, all state holds (reset excepted).
REQ-005 SHALL have port carrier, input, 16: carrier count from the upstream 16-bit PWM timer.
REQ-006 SHALL have port sync, input, 1: timer sync pulse (carrier min/max per the timer's sync mask).
REQ-007 SHALL have port compare, input, 16: duty compare value, shadowed.
REQ-008 SHALL have port deadtime, input, DT_WIDTH: dead-time length in ce-cycles.
REQ-009 SHALL have port enable, input, 1: gate output enable.
REQ-010 SHALL have port pwm_h, output, 1: high-side gate, registered.
REQ-011 SHALL have port pwm_l, output, 1: low-side gate, registered.
REQ-012 SHALL have port cmp_active, output, 16: compare value currently in use.
REQ-013 SHALL have port in_dt, output, 1: high while in a dead-time state.

Function
REQ-014 Shadow load: on a ce cycle with sync=1, cmp_active SHALL load compare at that edge; otherwise it holds (glitch-free duty update).
REQ-015 Raw compare: on each ce edge, raw_q SHALL register (carrier < cmp_active), unsigned 16-bit, using cmp_active's pre-edge value.
REQ-016 Boundaries: cmp_active=0 SHALL give raw_q=0 permanently; cmp_active greater than the maximum carrier SHALL give raw_q=1 permanently.
REQ-017 FSM states: OFF, H_ON, DT_TO_L, L_ON, DT_TO_H; pwm_h=1 only in H_ON, pwm_l=1 only in L_ON, in_dt=1 only in DT_TO_L/DT_TO_H.
REQ-018 pwm_h and pwm_l SHALL never be high on the same cycle, under any input sequence.
REQ-019 OFF: with enable=1, SHALL move to DT_TO_H if raw_q=1, else DT_TO_L (full dead time before first turn-on).
REQ-020 H_ON: raw_q=0 SHALL move to DT_TO_L; L_ON: raw_q=1 SHALL move to DT_TO_H.
REQ-021 Dead-time counter SHALL load deadtime on DT entry, decrement once per ce cycle, and exit when it reaches 0, giving exactly deadtime ce-cycles with both outputs low.
REQ-022 deadtime=0: transitions SHALL go directly H_ON<->L_ON (or OFF->ON) without a dead-time cycle.
REQ-023 DT exit SHALL go to H_ON if raw_q=1 at exit, else L_ON; a raw_q toggle during dead time SHALL NOT restart or shorten the count.
REQ-024 The deadtime value SHALL be sampled only on DT entry; changes mid-count SHALL take effect on the next entry.
REQ-025 enable=0 SHALL force OFF at the next ce edge from any state, aborting any dead time; this SHALL take priority over all other transitions.
REQ-026 Latency: a carrier crossing cmp_active at edge k SHALL update raw_q at edge k+1; the outgoing gate SHALL fall at k+2; the incoming gate SHALL rise at k+2+deadtime (ce continuously high).
REQ-027 ce=0 SHALL freeze cmp_active, raw_q, the state, and the counter; outputs SHALL hold.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL set cmp_active=0, raw_q=0, state OFF, counter=0, pwm_h=0, pwm_l=0, in_dt=0, regardless of ce.
REQ-029 Reset mid-dead-time or mid-ON SHALL take effect at that edge; after release, the block SHALL restart from OFF per REQ-019.

Verification
REQ-030 Timer up/down with countmax=0x00FF, compare=0x0080, deadtime=4, enable=1 -> pwm_h duty about 50%; each edge has exactly 4 cycles with both gates low; no overlap.
REQ-031 Change compare 0x0080->0x0040 between syncs -> cmp_active changes only on the first cycle with sync=1; duty is about 25% from the next carrier period.
REQ-032 compare=0 -> pwm_l held high and pwm_h low after the initial dead time; compare=0xFFFF with countmax=0x00FF -> pwm_h held high.
REQ-033 deadtime=0 -> the two gates switch on the same edge with no gap; deadtime=255 with a 100-cycle half period -> dead time completes (255 cycles), and the state then follows raw_q at exit.
REQ-034 Deassert enable during DT_TO_H -> both gates 0 and in_dt=0 on the next edge; reassert -> full dead time precedes turn-on.
REQ-035 Hold ce=0 for 10 cycles mid dead-time, then assert rst mid-operation -> the counter and outputs freeze while ce=0; after rst, all outputs read 0 on the next cycle.

Source files
------------

// File: rtl/pwm_compare_deadtime.sv
// Complementary gate driver: compares a PWM carrier against a sync-shadowed
// duty value and inserts a programmable dead time between high- and low-side turn-on.
module pwm_compare_deadtime #(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic [15:0]         carrier,
  input  logic                sync,
  input  logic [15:0]         compare,
  input  logic [DT_WIDTH-1:0] deadtime,
  input  logic                enable,
  output logic                pwm_h,
  output logic                pwm_l,
  output logic [15:0]         cmp_active,
  output logic                in_dt
);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_H_ON,
    ST_DT_TO_L,
    ST_L_ON,
    ST_DT_TO_H
  } state_t;

  state_t              state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic [15:0]         cmp_q, cmp_d;
  logic                raw_q, raw_d;
  logic                pwm_h_q, pwm_l_q, in_dt_q;
  logic                dt_zero;

  assign dt_zero = (deadtime == '0);
  assign cmp_d   = sync ? compare : cmp_q;
  assign raw_d   = (carrier < cmp_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (dt_zero) begin
            state_d = raw_q ? ST_H_ON : ST_L_ON;
          end else begin
            state_d = raw_q ? ST_DT_TO_H : ST_DT_TO_L;
            cnt_d   = deadtime;
          end
        end
        ST_H_ON: begin
          if (!raw_q) begin
            if (dt_zero) begin
              state_d = ST_L_ON;
            end else begin
              state_d = ST_DT_TO_L;
              cnt_d   = deadtime;
            end
          end
        end
        ST_L_ON: begin
          if (raw_q) begin
            if (dt_zero) begin
              state_d = ST_H_ON;
            end else begin
              state_d = ST_DT_TO_H;
              cnt_d   = deadtime;
            end
          end
        end
        ST_DT_TO_L, ST_DT_TO_H: begin
          // Exit direction is decided by raw_q at exit, not by which DT state we are in.
          if (cnt_q <= DT_WIDTH'(1)) begin
            state_d = raw_q ? ST_H_ON : ST_L_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - DT_WIDTH'(1);
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_q   <= '0;
      raw_q   <= 1'b0;
      state_q <= ST_OFF;
      cnt_q   <= '0;
      pwm_h_q <= 1'b0;
      pwm_l_q <= 1'b0;
      in_dt_q <= 1'b0;
    end else if (ce) begin
      cmp_q   <= cmp_d;
      raw_q   <= raw_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Gates are decoded from the next state so they toggle on the same edge as the state.
      pwm_h_q <= (state_d == ST_H_ON);
      pwm_l_q <= (state_d == ST_L_ON);
      in_dt_q <= (state_d == ST_DT_TO_L) || (state_d == ST_DT_TO_H);
    end
  end

  assign pwm_h      = pwm_h_q;
  assign pwm_l      = pwm_l_q;
  assign in_dt      = in_dt_q;
  assign cmp_active = cmp_q;

endmodule

// File: tb/tb_pwm_compare_deadtime.sv
// Directed bench for pwm_compare_deadtime; gate vectors are {pwm_h, pwm_l, in_dt}.
module tb_pwm_compare_deadtime;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [15:0] carrier;
  logic        sync;
  logic [15:0] compare;
  logic [7:0]  deadtime;
  logic        enable;
  logic        pwm_h;
  logic        pwm_l;
  logic [15:0] cmp_active;
  logic        in_dt;
  logic [2:0]  gates;

  int checks = 0;
  int errors = 0;

  assign gates = {pwm_h, pwm_l, in_dt};

  pwm_compare_deadtime #(.DT_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .carrier    (carrier),
    .sync       (sync),
    .compare    (compare),
    .deadtime   (deadtime),
    .enable     (enable),
    .pwm_h      (pwm_h),
    .pwm_l      (pwm_l),
    .cmp_active (cmp_active),
    .in_dt      (in_dt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, load the shadow compare on a sync cycle, then let raw settle to (car < cmp).
  task automatic start_run(input logic [7:0] dt, input logic [15:0] cmp, input logic [15:0] car);
    rst = 1'b1; ce = 1'b1; enable = 1'b0; sync = 1'b0;
    tick();
    rst = 1'b0;
    deadtime = dt; compare = cmp; sync = 1'b1; carrier = car;
    tick();
    sync = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    $display("test_reset");
    rst = 1'b1; ce = 1'b0; enable = 1'b1; sync = 1'b1;
    carrier = 16'h0010; compare = 16'h1234; deadtime = 8'd3;
    tick();
    checks++;
    if (gates !== 3'b000) begin
      errors++; $display("FAIL reset_gates: got %b expected %b", gates, 3'b000);
    end
    checks++;
    if (cmp_active !== 16'h0000) begin
      errors++; $display("FAIL reset_cmp: got %h expected %h", cmp_active, 16'h0000);
    end
    rst = 1'b0;
  endtask

  task automatic test_shadow();
    $display("test_shadow");
    start_run(8'd4, 16'h0080, 16'h0010);
    checks++;
    if (cmp_active !== 16'h0080) begin
      errors++; $display("FAIL shadow_load: got %h expected %h", cmp_active, 16'h0080);
    end
    compare = 16'h0040;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (cmp_active !== 16'h0080) begin
        errors++; $display("FAIL shadow_hold[%0d]: got %h expected %h", i, cmp_active, 16'h0080);
      end
    end
    sync = 1'b1;
    tick();
    sync = 1'b0;
    checks++;
    if (cmp_active !== 16'h0040) begin
      errors++; $display("FAIL shadow_update: got %h expected %h", cmp_active, 16'h0040);
    end
    checks++;
    if (gates !== 3'b000) begin
      errors++; $display("FAIL shadow_disabled_gates: got %b expected %b", gates, 3'b000);
    end
  endtask

  task automatic test_deadtime_seq();
    $display("test_deadtime_seq");
    start_run(8'd4, 16'h0080, 16'h0010);
    enable = 1'b1;
    // OFF -> DT_TO_H: four dead cycles, then high side on.
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (gates !== 3'b001) begin
        errors++; $display("FAIL first_dt[%0d]: got %b expected %b", i, gates, 3'b001);
      end
    end
    tick();
    checks++;
    if (gates !== 3'b100) begin
      errors++; $display("FAIL first_h_on: got %b expected %b", gates, 3'b100);
    end
    // Carrier crosses: raw updates this edge, pwm_h falls next edge.
    carrier = 16'h0090;
    tick();
    checks++;
    if (gates !== 3'b100) begin
      errors++; $display("FAIL h_latency: got %b expected %b", gates, 3'b100);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (gates !== 3'b001) begin
        errors++; $display("FAIL dt_to_l[%0d]: got %b expected %b", i, gates, 3'b001);
      end
    end
    tick();
    checks++;
    if (gates !== 3'b010) begin
      errors++; $display("FAIL l_on: got %b expected %b", gates, 3'b010);
    end
    carrier = 16'h0010;
    tick();
    checks++;
    if (gates !== 3'b010) begin
      errors++; $display("FAIL l_latency: got %b expected %b", gates, 3'b010);
    end
    tick();
    checks++;
    if (gates !== 3'b001) begin
      errors++; $display("FAIL dt_to_h_entry: got %b expected %b", gates, 3'b001);
    end
    // Mid-count: new deadtime and raw toggle must not change this dead time.
    deadtime = 8'd10; carrier = 16'h0090;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (gates !== 3'b001) begin
        errors++; $display("FAIL dt_no_restart[%0d]: got %b expected %b", i, gates, 3'b001);
      end
    end
    tick();
    checks++;
    if (gates !== 3'b010) begin
      errors++; $display("FAIL exit_follows_raw: got %b expected %b", gates, 3'b010);
    end
    carrier = 16'h0010;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (gates !== 3'b001) begin
        errors++; $display("FAIL new_deadtime[%0d]: got %b expected %b", i, gates, 3'b001);
      end
    end
    tick();
    checks++;
    if (gates !== 3'b100) begin
      errors++; $display("FAIL new_deadtime_h_on: got %b expected %b", gates, 3'b100);
    end
    // Reset while ON takes effect at the edge.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (gates !== 3'b000) begin
      errors++; $display("FAIL reset_mid_on: got %b expected %b", gates, 3'b000);
    end
  endtask

  task automatic test_deadtime_zero();
    $display("test_deadtime_zero");
    start_run(8'd0, 16'h0080, 16'h0010);
    enable = 1'b1;
    tick();
    checks++;
    if (gates !== 3'b100) begin
      errors++; $display("FAIL dt0_off_to_h: got %b expected %b", gates, 3'b100);
    end
    carrier = 16'h0090;
    tick();
    checks++;
    if (gates !== 3'b100) begin
      errors++; $display("FAIL dt0_h_hold: got %b expected %b", gates, 3'b100);
    end
    tick();
    checks++;
    if (gates !== 3'b010) begin
      errors++; $display("FAIL dt0_h_to_l: got %b expected %b", gates, 3'b010);
    end
    carrier = 16'h0010;
    tick();
    tick();
    checks++;
    if (gates !== 3'b100) begin
      errors++; $display("FAIL dt0_l_to_h: got %b expected %b", gates, 3'b100);
    end
  endtask

  task automatic test_boundaries();
    $display("test_boundaries");
    start_run(8'd4, 16'h0000, 16'h0000);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 6; i++) begin
      carrier = 16'(i * 51);
      tick();
      checks++;
      if (gates !== 3'b010) begin
        errors++; $display("FAIL cmp_zero_low[%0d]: got %b expected %b", i, gates, 3'b010);
      end
    end
    compare = 16'hFFFF; sync = 1'b1;
    tick();
    sync = 1'b0; carrier = 16'h00FF;
    tick();
    checks++;
    if (gates !== 3'b010) begin
      errors++; $display("FAIL cmp_max_latency: got %b expected %b", gates, 3'b010);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (gates !== 3'b001) begin
        errors++; $display("FAIL cmp_max_dt[%0d]: got %b expected %b", i, gates, 3'b001);
      end
    end
    for (int i = 0; i < 6; i++) begin
      carrier = 16'(255 - i * 51);
      tick();
      checks++;
      if (gates !== 3'b100) begin
        errors++; $display("FAIL cmp_max_high[%0d]: got %b expected %b", i, gates, 3'b100);
      end
    end
  endtask

  task automatic test_long_deadtime();
    $display("test_long_deadtime");
    start_run(8'd255, 16'h0080, 16'h0010);
    enable = 1'b1;
    for (int i = 0; i < 255; i++) begin
      carrier = (i < 100) ? 16'h0010 : 16'h0090;
      tick();
      checks++;
      if (gates !== 3'b001) begin
        errors++; $display("FAIL long_dt[%0d]: got %b expected %b", i, gates, 3'b001);
      end
    end
    tick();
    checks++;
    if (gates !== 3'b010) begin
      errors++; $display("FAIL long_dt_exit: got %b expected %b", gates, 3'b010);
    end
  endtask

  task automatic test_enable_abort();
    $display("test_enable_abort");
    start_run(8'd4, 16'h0080, 16'h0010);
    enable = 1'b1;
    tick();
    tick();
    enable = 1'b0;
    tick();
    checks++;
    if (gates !== 3'b000) begin
      errors++; $display("FAIL abort_dt: got %b expected %b", gates, 3'b000);
    end
    tick();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (gates !== 3'b001) begin
        errors++; $display("FAIL reenable_dt[%0d]: got %b expected %b", i, gates, 3'b001);
      end
    end
    tick();
    checks++;
    if (gates !== 3'b100) begin
      errors++; $display("FAIL reenable_h_on: got %b expected %b", gates, 3'b100);
    end
  endtask

  task automatic test_ce_freeze();
    $display("test_ce_freeze");
    start_run(8'd4, 16'h0080, 16'h0010);
    enable = 1'b1;
    tick();
    tick();
    ce = 1'b0; carrier = 16'h0090; compare = 16'h0020; sync = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (gates !== 3'b001 || cmp_active !== 16'h0080) begin
        errors++;
        $display("FAIL ce_freeze[%0d]: got %b/%h expected %b/%h", i, gates, cmp_active, 3'b001, 16'h0080);
      end
    end
    ce = 1'b1; carrier = 16'h0010; sync = 1'b0;
    tick();
    tick();
    checks++;
    if (gates !== 3'b001) begin
      errors++; $display("FAIL ce_resume_dt: got %b expected %b", gates, 3'b001);
    end
    tick();
    checks++;
    if (gates !== 3'b100) begin
      errors++; $display("FAIL ce_resume_h_on: got %b expected %b", gates, 3'b100);
    end
    ce = 1'b0; rst = 1'b1;
    tick();
    checks++;
    if (gates !== 3'b000 || cmp_active !== 16'h0000) begin
      errors++;
      $display("FAIL reset_ce_low: got %b/%h expected %b/%h", gates, cmp_active, 3'b000, 16'h0000);
    end
    rst = 1'b0; ce = 1'b1;
    tick();
    checks++;
    if (gates !== 3'b001) begin
      errors++; $display("FAIL restart_from_off: got %b expected %b", gates, 3'b001);
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; carrier = '0; sync = 1'b0;
    compare = '0; deadtime = '0; enable = 1'b0;
    test_reset();
    test_shadow();
    test_deadtime_seq();
    test_deadtime_zero();
    test_boundaries();
    test_long_deadtime();
    test_enable_abort();
    test_ce_freeze();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
